// File: rtl/csa_pipe_adder.sv
`default_nettype none
// ============================================================================
// Module   : csa_pipe_adder
// Brief    : Pipelined carry-skip adder/subtractor. Each BLOCK-bit block
//            resolves in its own stage. Valid/ready handshake on both sides.
//            Reports carry-out, signed overflow and a per-block skip mask.
// Revision : 1.0 - initial release
// ============================================================================
module csa_pipe_adder #(
    parameter int WIDTH = 16,   // multiple of BLOCK, at least BLOCK
    parameter int BLOCK = 4
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   in_valid,
    output logic                   in_ready,
    input  logic [WIDTH-1:0]       A,
    input  logic [WIDTH-1:0]       B,
    input  logic                   carryin,
    input  logic                   sub,
    output logic                   out_valid,
    input  logic                   out_ready,
    output logic [WIDTH-1:0]       Y,
    output logic                   carryout,
    output logic                   overflow,
    output logic [WIDTH/BLOCK-1:0] skipmask
);

    localparam int c_nblk = WIDTH / BLOCK;

    // One global advance enable: the whole pipe moves or the whole pipe holds.
    logic w_en;
    assign w_en     = !out_valid || out_ready;
    assign in_ready = w_en;

    for (genvar k = 0; k < c_nblk; k++) begin : g_stage
        // Operand bits still unresolved when entering this stage (block k upward)
        localparam int c_rem_in = WIDTH - k * BLOCK;

        logic [c_rem_in-1:0]    w_a_in;
        logic [c_rem_in-1:0]    w_b_in;
        logic                   w_cin;
        logic                   w_vld_in;
        logic [BLOCK-1:0]       w_blk_sum;
        logic                   w_ripple_c;
        logic                   w_blk_p;
        logic                   w_blk_cout;
        logic [(k+1)*BLOCK-1:0] w_sum_d;
        logic [k:0]             w_skip_d;

        logic                   r_vld;
        logic                   r_cout;
        logic [(k+1)*BLOCK-1:0] r_sum;
        logic [k:0]             r_skip;

        if (k == 0) begin : g_src_port
            // Subtraction is A + ~B + 1; carryin is ignored in that mode
            assign w_a_in   = A;
            assign w_b_in   = sub ? ~B : B;
            assign w_cin    = sub | carryin;
            assign w_vld_in = in_valid;
            assign w_sum_d  = w_blk_sum;
            assign w_skip_d = w_blk_p;
        end else begin : g_src_stage
            assign w_a_in   = g_stage[k-1].g_fwd.r_a;
            assign w_b_in   = g_stage[k-1].g_fwd.r_b;
            assign w_cin    = g_stage[k-1].r_cout;
            assign w_vld_in = g_stage[k-1].r_vld;
            assign w_sum_d  = {w_blk_sum, g_stage[k-1].r_sum};
            assign w_skip_d = {w_blk_p, g_stage[k-1].r_skip};
        end

        // Ripple the block, then pick the skip path when every bit propagates
        always_comb begin
            w_blk_sum  = '0;
            w_ripple_c = w_cin;
            for (int i = 0; i < BLOCK; i++) begin
                w_blk_sum[i] = w_a_in[i] ^ w_b_in[i] ^ w_ripple_c;
                w_ripple_c   = (w_a_in[i] & w_b_in[i]) |
                               (w_ripple_c & (w_a_in[i] ^ w_b_in[i]));
            end
            w_blk_p    = &(w_a_in[BLOCK-1:0] ^ w_b_in[BLOCK-1:0]);
            w_blk_cout = w_blk_p ? w_cin : w_ripple_c;
        end

        // Stage register: token valid, resolved sum slices, carry and skip bits
        always_ff @(posedge clk or posedge reset) begin
            if (reset) begin
                r_vld  <= 1'b0;
                r_cout <= 1'b0;
                r_sum  <= '0;
                r_skip <= '0;
            end else if (w_en) begin
                r_vld  <= w_vld_in;
                r_cout <= w_blk_cout;
                r_sum  <= w_sum_d;
                r_skip <= w_skip_d;
            end
        end

        if (k < c_nblk - 1) begin : g_fwd
            logic [c_rem_in-BLOCK-1:0] r_a;
            logic [c_rem_in-BLOCK-1:0] r_b;

            // Unresolved upper operand blocks travel with the token
            always_ff @(posedge clk or posedge reset) begin
                if (reset) begin
                    r_a <= '0;
                    r_b <= '0;
                end else if (w_en) begin
                    r_a <= w_a_in[c_rem_in-1:BLOCK];
                    r_b <= w_b_in[c_rem_in-1:BLOCK];
                end
            end
        end else begin : g_last
            logic r_ovf;

            // Carry into the MSB is recovered as a^b^sum at that bit
            always_ff @(posedge clk or posedge reset) begin
                if (reset) begin
                    r_ovf <= 1'b0;
                end else if (w_en) begin
                    r_ovf <= w_a_in[BLOCK-1] ^ w_b_in[BLOCK-1] ^
                             w_blk_sum[BLOCK-1] ^ w_blk_cout;
                end
            end
        end
    end

    assign out_valid = g_stage[c_nblk-1].r_vld;
    assign Y         = g_stage[c_nblk-1].r_sum;
    assign carryout  = g_stage[c_nblk-1].r_cout;
    assign overflow  = g_stage[c_nblk-1].g_last.r_ovf;
    assign skipmask  = g_stage[c_nblk-1].r_skip;

endmodule
`default_nettype wire

// File: tb/tb_csa_pipe_adder.sv
`default_nettype none
// ============================================================================
// Module   : tb_csa_pipe_adder
// Brief    : Self-checking bench for csa_pipe_adder (16/4 and 8/8 instances)
// Revision : 1.0 - initial release
// ============================================================================
module tb_csa_pipe_adder;

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    logic        in_valid, in_ready, carryin, sub, out_valid, out_ready;
    logic        carryout, overflow;
    logic [15:0] A, B, Y;
    logic [3:0]  skipmask;

    logic        in_valid8, in_ready8, carryin8, sub8, out_valid8, out_ready8;
    logic        carryout8, overflow8;
    logic [7:0]  a8, b8, y8;
    logic [0:0]  skipmask8;

    csa_pipe_adder #(.WIDTH(16), .BLOCK(4)) dut (
        .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready),
        .A(A), .B(B), .carryin(carryin), .sub(sub),
        .out_valid(out_valid), .out_ready(out_ready), .Y(Y),
        .carryout(carryout), .overflow(overflow), .skipmask(skipmask)
    );

    csa_pipe_adder #(.WIDTH(8), .BLOCK(8)) dut8 (
        .clk(clk), .reset(reset), .in_valid(in_valid8), .in_ready(in_ready8),
        .A(a8), .B(b8), .carryin(carryin8), .sub(sub8),
        .out_valid(out_valid8), .out_ready(out_ready8), .Y(y8),
        .carryout(carryout8), .overflow(overflow8), .skipmask(skipmask8)
    );

    typedef struct packed {
        logic [15:0] y;
        logic        co;
        logic        ov;
        logic [3:0]  sk;
    } res_t;

    res_t exp_q[$];
    res_t out_log[$];
    int   n_cmp = 0;
    int   n_bad = 0;
    bit   saw_stall = 0;
    bit   rand_done;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Reference: plain integer arithmetic for sum/carry/overflow
    function automatic res_t model(input logic [15:0] a, input logic [15:0] b,
                                   input logic ci, input logic sb);
        res_t        r;
        logic [16:0] full;
        logic [15:0] be;
        int          sa, sbv, s;
        be  = sb ? ~b : b;
        sa  = $signed(a);
        sbv = $signed(b);
        if (sb) begin
            full = {1'b0, a} + {1'b0, be} + 17'd1;
            s    = sa - sbv;
        end else begin
            full = {1'b0, a} + {1'b0, b} + {16'd0, ci};
            s    = sa + sbv + (ci ? 1 : 0);
        end
        r.y  = full[15:0];
        r.co = full[16];
        r.ov = (s > 32767) || (s < -32768);
        for (int k = 0; k < 4; k++) r.sk[k] = &(a[4*k +: 4] ^ be[4*k +: 4]);
        return r;
    endfunction

    function automatic logic [15:0] pick();
        case ($urandom_range(0, 5))
            0:       return 16'h0000;
            1:       return 16'hFFFF;
            2:       return 16'h7FFF;
            3:       return 16'h8000;
            default: return 16'($urandom);
        endcase
    endfunction

    // Compare process: scoreboard on every negedge
    initial begin : monitor
        res_t got, held, e;
        bit   held_v;
        held_v = 0;
        forever begin
            @(negedge clk);
            if (reset) begin
                exp_q.delete();
                held_v = 0;
            end else begin
                if (in_valid && in_ready) exp_q.push_back(model(A, B, carryin, sub));
                check("in_ready_rule", in_ready, !out_valid || out_ready);
                if (!in_ready) saw_stall = 1;
                if (out_valid) begin
                    got.y = Y; got.co = carryout; got.ov = overflow; got.sk = skipmask;
                    if (held_v) check("hold_stable", got, held);
                    if (out_ready) begin
                        check("output_has_pending_input", exp_q.size() != 0, 1'b1);
                        if (exp_q.size() != 0) begin
                            e = exp_q.pop_front();
                            check("result", got, e);
                            out_log.push_back(got);
                        end
                        held_v = 0;
                    end else begin
                        held   = got;
                        held_v = 1;
                    end
                end else begin
                    held_v = 0;
                end
            end
        end
    end

    task automatic send(input logic [15:0] a, input logic [15:0] b, input logic ci, input logic sb);
        bit acc;
        int n;
        A = a; B = b; carryin = ci; sub = sb; in_valid = 1'b1;
        acc = 0; n = 0;
        while (!acc && n < 100) begin
            @(negedge clk);
            acc = in_ready;
            @(posedge clk); #1;
            n++;
        end
        in_valid = 1'b0;
        check("send_accepted", acc, 1'b1);
    endtask

    task automatic lat_op(input logic [15:0] a, input logic [15:0] b, input logic ci, input logic sb);
        A = a; B = b; carryin = ci; sub = sb; in_valid = 1'b1;
        @(negedge clk);
        check("lat_in_ready", in_ready, 1'b1);
        @(posedge clk); #1;
        in_valid = 1'b0;
        check("lat_edge0", out_valid, 1'b0);
        repeat (2) begin
            @(posedge clk); #1;
            check("lat_mid", out_valid, 1'b0);
        end
        @(posedge clk); #1;
        check("lat_out", out_valid, 1'b1);
    endtask

    task automatic wait_drain();
        int n;
        n = 0;
        while ((exp_q.size() != 0 || out_valid) && n < 60) begin
            @(posedge clk); #1;
            n++;
        end
        check("drain_in_time", n < 60, 1'b1);
    endtask

    initial begin : watchdog
        #500000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin : main
        int base;
        reset = 1'b1; in_valid = 1'b0; out_ready = 1'b1;
        A = '0; B = '0; carryin = 1'b0; sub = 1'b0;
        in_valid8 = 1'b0; out_ready8 = 1'b1; a8 = '0; b8 = '0; carryin8 = 1'b0; sub8 = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check("rst_out_valid", out_valid, 1'b0);
        check("rst_Y", Y, 16'h0000);
        check("rst_carryout", carryout, 1'b0);
        check("rst_overflow", overflow, 1'b0);
        check("rst_skipmask", skipmask, 4'b0000);
        reset = 1'b0;

        // Single-block instance: result one cycle after acceptance
        a8 = 8'hFF; b8 = 8'hFF; carryin8 = 1'b1; in_valid8 = 1'b1;
        @(negedge clk);
        check("w8_in_ready", in_ready8, 1'b1);
        @(posedge clk); #1;
        in_valid8 = 1'b0;
        check("w8_out_valid", out_valid8, 1'b1);
        check("w8_Y", y8, 8'hFF);
        check("w8_carryout", carryout8, 1'b1);
        check("w8_skipmask", skipmask8, 1'b0);
        check("w8_overflow", overflow8, 1'b0);
        @(posedge clk); #1;
        check("w8_single", out_valid8, 1'b0);

        // Directed ops
        lat_op(16'h0000, 16'h0000, 1'b0, 1'b0);
        send(16'h00FF, 16'hFF00, 1'b1, 1'b0);
        send(16'hFFFF, 16'h0001, 1'b0, 1'b0);
        send(16'h0005, 16'h0007, 1'b0, 1'b1);
        send(16'h7FFF, 16'h0001, 1'b0, 1'b0);
        wait_drain();
        check("log_count_directed", out_log.size(), 5);
        if (out_log.size() >= 5) begin
            check("pin_zero",     out_log[0], {16'h0000, 1'b0, 1'b0, 4'b0000});
            check("pin_allskip",  out_log[1], {16'h0000, 1'b1, 1'b0, 4'b1111});
            check("pin_ffff_p1",  out_log[2], {16'h0000, 1'b1, 1'b0, 4'b1110});
            check("pin_sub_5_7",  out_log[3], {16'hFFFE, 1'b0, 1'b0, 4'b1110});
            check("pin_ovf",      out_log[4], {16'h8000, 1'b0, 1'b1, 4'b0110});
        end

        // Back-to-back stream with a 3-cycle output stall
        base = out_log.size();
        fork
            begin
                send(16'h00FF, 16'h00FF, 1'b0, 1'b0);
                send(16'h0003, 16'h0002, 1'b1, 1'b0);
                send(16'h0007, 16'h000A, 1'b0, 1'b0);
                send(16'h000F, 16'h000F, 1'b1, 1'b0);
                send(16'h00FF, 16'h0037, 1'b0, 1'b0);
                send(16'h00FF, 16'h00FF, 1'b1, 1'b0);
            end
            begin
                repeat (5) @(posedge clk);
                #1 out_ready = 1'b0;
                repeat (3) @(posedge clk);
                #1 out_ready = 1'b1;
            end
        join
        wait_drain();
        check("stream_stalled", saw_stall, 1'b1);
        check("log_count_stream", out_log.size(), base + 6);
        if (out_log.size() >= base + 6) begin
            check("pin_s0", out_log[base+0].y, 16'h01FE);
            check("pin_s1", out_log[base+1].y, 16'h0006);
            check("pin_s2", out_log[base+2].y, 16'h0011);
            check("pin_s3", out_log[base+3].y, 16'h001F);
            check("pin_s4", out_log[base+4].y, 16'h0136);
            check("pin_s5", out_log[base+5].y, 16'h01FF);
        end

        // Reset with operations in flight
        out_ready = 1'b0;
        send(16'h0001, 16'h0002, 1'b0, 1'b0);
        send(16'h0003, 16'h0004, 1'b0, 1'b0);
        send(16'h0005, 16'h0006, 1'b0, 1'b0);
        @(posedge clk); #1;
        check("pre_reset_valid", out_valid, 1'b1);
        reset = 1'b1;
        #1;
        check("async_rst_valid", out_valid, 1'b0);
        check("async_rst_Y", Y, 16'h0000);
        check("async_rst_skip", skipmask, 4'b0000);
        repeat (2) @(posedge clk);
        #1 reset = 1'b0;
        out_ready = 1'b1;
        base = out_log.size();
        repeat (8) @(posedge clk);
        #1;
        check("post_reset_quiet", out_log.size(), base);
        lat_op(16'h1234, 16'h4321, 1'b0, 1'b0);
        wait_drain();
        check("post_reset_count", out_log.size(), base + 1);
        if (out_log.size() == base + 1) check("pin_post_reset", out_log[base].y, 16'h5555);

        // Randomized traffic with random back-pressure and bubbles
        rand_done = 0;
        fork
            begin
                for (int i = 0; i < 300; i++) begin
                    if ($urandom_range(0, 3) == 0) begin
                        @(posedge clk); #1;
                    end
                    send(pick(), pick(), 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
                end
                rand_done = 1;
            end
            begin
                while (!rand_done) begin
                    out_ready = ($urandom_range(0, 3) != 0);
                    @(posedge clk); #1;
                end
                out_ready = 1'b1;
            end
        join
        wait_drain();
        check("no_loss", exp_q.size(), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/csa_pipe_adder.md
Name: csa_pipe_adder

Overview:
- Parametrised, pipelined carry-skip adder/subtractor. Successor to the fixed 8-bit combinational carry-skip adder.
- Operands are split into blocks of BLOCK bits. Each block resolves in its own pipeline stage; its carry uses the skip path when the whole block propagates.
- Valid/ready handshake on both sides, so it sits directly in datapath streams (ALU lanes, accumulators).
- Reports carry, signed overflow and a per-block skip mask for each result.

Parameters:
- WIDTH, 16, operand/sum width in bits; must be a multiple of BLOCK and at least BLOCK.
- BLOCK, 4, carry-skip block size in bits; NBLK = WIDTH/BLOCK = pipeline depth.

Ports:
- clk  input  1  rising-edge clock
- reset  input  1  asynchronous, active-high reset
- in_valid  input  1  operand set present
- in_ready  output  1  block accepts operands this cycle
- A  input  WIDTH  operand A
- B  input  WIDTH  operand B
- carryin  input  1  carry into bit 0 (add mode only)
- sub  input  1  1 = subtract (A - B), 0 = add
- out_valid  output  1  result present
- out_ready  input  1  consumer accepts result
- Y  output  WIDTH  sum/difference
- carryout  output  1  carry out of MSB (borrow-not in sub mode)
- overflow  output  1  two's-complement overflow
- skipmask  output  NBLK  bit k = 1 if block k's carry-out took the skip path

Behaviour:
- Reset, async, immediate: all stage valid bits = 0, out_valid = 0, Y = 0, carryout = 0, overflow = 0, skipmask = 0. Reset mid-operation discards every in-flight operation.
- Effective operands: Beff = sub ? ~B : B; cin0 = sub ? 1 : carryin. carryin is ignored when sub = 1.
- Stage k (k = 0..NBLK-1) takes block k of A and Beff plus the carry from stage k-1 (cin0 for k = 0).
  - Computes the block sum by ripple.
  - P_k = AND of (A_k XOR Beff_k).
  - cout_k = P_k ? cin_k : ripple carry-out.
  - skipmask[k] = P_k.
- Each stage registers its sum slice, cout and skipmask bits. Unresolved high operand blocks travel with the token; lower resolved sum slices travel with it too.
- Latency: an operand accepted at edge t has its result visible (out_valid = 1) after edge t+NBLK-1. With NBLK = 1, the result is visible the cycle after acceptance.
- Throughput: one op per cycle when not stalled.
- Handshake:
  - Input transfer when in_valid & in_ready.
  - Output transfer when out_valid & out_ready.
  - Global advance enable en = !out_valid | out_ready; in_ready = en.
  - When en = 0, all stages hold. Y, carryout, overflow and skipmask stay stable while out_valid = 1 and out_ready = 0.
- Bubbles: a stage with valid = 0 propagates as a bubble. Bubbles are compressed only by draining at the output; there is no internal bubble collapse.
- Outputs:
  - carryout = cout of stage NBLK-1.
  - overflow = carry into MSB XOR carry out of MSB, computed in the last stage.
  - Y = concatenated registered slices.
- Width rule: no truncation. Carry beyond WIDTH is reported only in carryout.
- Simultaneous input accept and output drain in the same cycle is legal, and the pipeline shifts.
- Data outputs are don't-care when out_valid = 0 but must not be X after reset.

Test Plan:
- Reset, then A=0x0000, B=0x0000, carryin=0, sub=0, out_ready=1 -> after 4 cycles: Y=0x0000, carryout=0, overflow=0, skipmask=4'b0000.
- A=0x00FF, B=0xFF00, carryin=1 -> Y=0x0000, carryout=1, skipmask=4'b1111. A=0xFFFF, B=0x0001, carryin=0 -> Y=0x0000, carryout=1, skipmask=4'b1110.
- sub=1, A=0x0005, B=0x0007 -> Y=0xFFFE, carryout=0, overflow=0. Add 0x7FFF+0x0001 -> Y=0x8000, overflow=1, carryout=0.
- Stream 6 ops back-to-back (0x00FF+0x00FF, 0x0003+0x0002+1, 0x0007+0x000A, 0x000F+0x000F+1, 0x00FF+0x0037, 0x00FF+0x00FF+1) with out_ready low 3 cycles mid-stream -> in_ready drops, no loss or duplication, results in order: 0x01FE, 0x0006, 0x0011, 0x001F, 0x0136, 0x01FF; held outputs stable while stalled.
- Assert reset with 3 ops in flight -> out_valid=0 immediately, nothing emitted afterwards. The next op after reset is released returns correctly with 4-cycle latency.
- Re-parametrise WIDTH=8, BLOCK=8 (NBLK=1): A=255, B=255, carryin=1 -> Y=0xFF, carryout=1, skipmask=1'b0, latency 1 cycle.
